spi_reg_bridge: RTL and testbench
=================================

Name: spi_reg_bridge

Overview:
- Converts the SPI byte stream from the slave-side byte deserializer into single-beat accesses on the internal 7-bit register bus. That bus is the one feeding the SD controller registers.
- Sits in top, downstream of the SPI byte receiver and upstream of the register file.
- Frame format:
  - Write: 0x89, {1,addr[6:0]}, data, dummy.
  - Read: 0x89, {0,addr[6:0]}, dummy. Read data is returned on MISO during the third byte.

Parameters:
- SYNC_BYTE, 8'h89, required first byte of every frame
- BUS_TIMEOUT, 16, clk cycles allowed for bus_ack before the access is abandoned
- ERR_BYTE, 8'hEE, tx byte presented when a read times out

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ss_active  in  1  chip select, synchronized to clk, high while the frame is selected
- rx_valid  in  1  one-cycle pulse, rx_byte complete
- rx_byte  in  8  received byte
- tx_byte  out  8  byte the shifter sends during the next SPI byte
- bus_addr  out  7  register address
- bus_wdata  out  8  write data
- bus_we  out  1  write request, held until ack/timeout
- bus_re  out  1  read request, held until ack/timeout
- bus_rdata  in  8  read data, valid with bus_ack
- bus_ack  in  1  one-cycle access completion
- frame_err  out  1  one-cycle pulse on any protocol error

Behaviour:
- Reset values: all outputs 0, tx_byte=8'h00, state IDLE.
- States: IDLE, CMD, DATA, TAIL, HUNT.
- Transitions:
  - IDLE: rx_valid with SYNC_BYTE -> CMD. Any other byte -> HUNT, pulse frame_err.
  - CMD: on rx_valid, latch addr=rx_byte[6:0] and wr=rx_byte[7].
    - Read: assert bus_re the next cycle; go to TAIL.
    - Write: go to DATA.
  - DATA: on rx_valid, latch bus_wdata, assert bus_we the next cycle, go to TAIL.
  - TAIL: the next rx_valid (dummy byte) -> IDLE.
  - HUNT: ignore all bytes until ss_active falls, then -> IDLE.
- ss_active low in any state forces IDLE the next cycle. An outstanding bus request is not withdrawn: it stays asserted until ack or timeout, and the FSM accepts no new frame until it ends.
- Bus rules:
  - bus_we and bus_re are never asserted together, and at most one request is outstanding.
  - Request rises 1 cycle after the triggering rx_valid and drops the cycle after bus_ack.
  - If BUS_TIMEOUT cycles elapse with no ack: drop the request and pulse frame_err. For a read, also set tx_byte=ERR_BYTE.
- tx_byte:
  - On read ack, tx_byte=bus_rdata in the cycle after ack; it holds until the next rx_valid.
  - At every other rx_valid, tx_byte returns to 8'h00.
- Overrun: rx_valid while a request is outstanding -> frame_err, state HUNT; the request still completes.
- Simultaneous rx_valid and ss_active falling: the byte is discarded and the FSM goes to IDLE.
- Reset mid-access: requests drop to 0 in the same edge.

Optional Feature:
- Macro SPI_REG_BRIDGE_ERRCNT_EN.
- Defined:
  - An 8-bit saturating counter increments on every frame_err.
  - A read of address 7'h7F is served locally with tx_byte=counter, the cycle after CMD, with no bus access.
  - A write of any value to 7'h7F clears the counter, with no bus access.
- Undefined: no counter; 7'h7F is forwarded to the bus like any other address.

Decomposition:
- Package spi_reg_bridge_pkg: state enum typedef, SYNC_BYTE default, ERR_BYTE default, ERRCNT_ADDR=7'h7F.
- No sub-module. The timeout counter and FSM stay inline; the error counter sits in the same module under ifdef.

Test Plan:
- Write frame 0x89,0xA4,0x23,0x00 with ack after 2 cycles -> one bus_we pulse-train, bus_addr=0x24, bus_wdata=0x23, no frame_err, state IDLE.
- Read frame 0x89,0x24,0x00 with bus_rdata=0x23 and ack after 3 cycles -> bus_re once, tx_byte=0x23 before the third rx_valid, then 0x00.
- Bad sync 0x55 followed by 0x89,0x81,0x01 in the same select -> frame_err once, no bus access; after ss_active falls, the next valid frame succeeds.
- Read with bus_ack never asserted -> bus_re drops after 16 cycles, frame_err pulses, tx_byte=0xEE.
- ss_active falls after the CMD byte of a write -> no bus_we, IDLE; the next write frame executes normally.
- With SPI_REG_BRIDGE_ERRCNT_EN: three bad-sync frames, then read 7'h7F -> tx_byte=0x03 with bus_re never asserted. Write 7'h7F, then read again -> 0x00.

Source files
------------

// File: rtl/spi_reg_bridge_pkg.sv
// Shared types and constants for the SPI-to-register-bus bridge.
package spi_reg_bridge_pkg;

    localparam int ADDR_W = 7;
    localparam int BUS_TIMEOUT_DEF = 16;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'h89;
    localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;
    localparam logic [ADDR_W-1:0] ERRCNT_ADDR = 7'h7F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_TAIL,
        ST_HUNT
    } state_e;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Single-beat register bus between the SPI bridge and the register file.
interface spi_reg_bridge_if;
    import spi_reg_bridge_pkg::*;

    logic [ADDR_W-1:0] bus_addr;
    logic [7:0] bus_wdata;
    logic bus_we;
    logic bus_re;
    logic [7:0] bus_rdata;
    logic bus_ack;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_we,
        output bus_re,
        input bus_rdata,
        input bus_ack
    );

    modport slave (
        input bus_addr,
        input bus_wdata,
        input bus_we,
        input bus_re,
        output bus_rdata,
        output bus_ack
    );

endinterface

// File: rtl/spi_reg_bridge.sv
// SPI byte stream to register bus bridge; define SPI_REG_BRIDGE_ERRCNT_EN
// for the local frame-error counter at address 7'h7F.
module spi_reg_bridge
    import spi_reg_bridge_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int BUS_TIMEOUT = BUS_TIMEOUT_DEF,
    parameter logic [7:0] ERR_BYTE = ERR_BYTE_DEF
) (
    input logic clk,
    input logic rst,
    input logic ss_active,
    input logic rx_valid,
    input logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic frame_err,
    spi_reg_bridge_if.master bus
);

    localparam int TW = $clog2(BUS_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUS_TIMEOUT - 1);

    state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] tx_q;
    logic we_q, re_q, err_q;
    logic [TW-1:0] tmo_q;

    logic busy, byte_ok, ack_evt, tmo_evt, err_d;
    logic sync_err, ovr_err, cmd_ld, data_ld;
    logic local_cmd, local_data;

    assign busy = we_q | re_q;
    assign byte_ok = rx_valid & ss_active;
    assign ack_evt = busy & bus.bus_ack;
    assign tmo_evt = busy & ~bus.bus_ack & (tmo_q == TMO_LAST);
    assign err_d = sync_err | ovr_err | tmo_evt;

`ifdef SPI_REG_BRIDGE_ERRCNT_EN
    logic [7:0] errcnt_q;

    assign local_cmd = (rx_byte[ADDR_W-1:0] == ERRCNT_ADDR);
    assign local_data = (addr_q == ERRCNT_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            errcnt_q <= 8'h00;
        end else if (data_ld && local_data) begin
            errcnt_q <= 8'h00;
        end else if (err_d && errcnt_q != 8'hFF) begin
            errcnt_q <= errcnt_q + 8'd1;
        end
    end
`else
    assign local_cmd = 1'b0;
    assign local_data = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else state_q <= state_d;
    end

    // Deselect wins over everything; a byte arriving with it is dropped.
    always_comb begin
        state_d = state_q;
        sync_err = 1'b0;
        ovr_err = 1'b0;
        cmd_ld = 1'b0;
        data_ld = 1'b0;
        if (!ss_active) begin
            state_d = ST_IDLE;
        end else if (rx_valid) begin
            if (busy && state_q != ST_HUNT) begin
                ovr_err = 1'b1;
                state_d = ST_HUNT;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state_d = ST_CMD;
                        end else begin
                            sync_err = 1'b1;
                            state_d = ST_HUNT;
                        end
                    end
                    ST_CMD: begin
                        cmd_ld = 1'b1;
                        state_d = rx_byte[7] ? ST_DATA : ST_TAIL;
                    end
                    ST_DATA: begin
                        data_ld = 1'b1;
                        state_d = ST_TAIL;
                    end
                    ST_TAIL: state_d = ST_IDLE;
                    ST_HUNT: state_d = ST_HUNT;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            wdata_q <= 8'h00;
            tx_q <= 8'h00;
            we_q <= 1'b0;
            re_q <= 1'b0;
            err_q <= 1'b0;
            tmo_q <= '0;
        end else begin
            err_q <= err_d;
            if (byte_ok) tx_q <= 8'h00;
            if (cmd_ld) begin
                addr_q <= rx_byte[ADDR_W-1:0];
                if (!rx_byte[7] && !local_cmd) begin
                    re_q <= 1'b1;
                    tmo_q <= '0;
                end
`ifdef SPI_REG_BRIDGE_ERRCNT_EN
                if (!rx_byte[7] && local_cmd) tx_q <= errcnt_q;
`endif
            end
            if (data_ld && !local_data) begin
                wdata_q <= rx_byte;
                we_q <= 1'b1;
                tmo_q <= '0;
            end
            // Read result overrides the byte-clear of an overrun byte.
            if (ack_evt || tmo_evt) begin
                we_q <= 1'b0;
                re_q <= 1'b0;
                if (re_q) tx_q <= ack_evt ? bus.bus_rdata : ERR_BYTE;
            end else if (busy) begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    assign tx_byte = tx_q;
    assign frame_err = err_q;
    assign bus.bus_addr = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_we = we_q;
    assign bus.bus_re = re_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: vector table, random frames against a frame-level
// model, and hand sequences for deselect, overrun, timeout and reset corners.
module tb_spi_reg_bridge;
    import spi_reg_bridge_pkg::*;

    localparam int GAP = 20;
    localparam int NRAND = 40;

    typedef struct {
        logic [3:0][7:0] by;
        int n;
        int lat;
        logic [7:0] rdata;
        int exp_we;
        int exp_re;
        logic [6:0] exp_addr;
        logic [7:0] exp_wdata;
        int exp_err;
        logic [7:0] exp_tx;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic ss_active;
    logic rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic frame_err;

    spi_reg_bridge_if bus ();

    spi_reg_bridge dut (
        .clk(clk),
        .rst(rst),
        .ss_active(ss_active),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .tx_byte(tx_byte),
        .frame_err(frame_err),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int we_rises = 0, re_rises = 0, err_pulses = 0, overlap = 0;
    int we_cycles = 0, re_cycles = 0, lat_cnt = 0;
    logic prev_we = 1'b0, prev_re = 1'b0;
    logic [6:0] seen_addr = '0;
    logic [7:0] seen_wdata = '0;
    int ack_lat;
    logic [7:0] rd_val;

    // Bus slave and monitor: ack comes ack_lat cycles into a request (0 = never).
    always @(negedge clk) begin
        if (rst) begin
            bus.bus_ack = 1'b0;
            bus.bus_rdata = 8'h00;
            lat_cnt = 0;
        end else begin
            if (bus.bus_we && bus.bus_re) overlap++;
            if (bus.bus_we && !prev_we) begin
                we_rises++;
                seen_addr = bus.bus_addr;
                seen_wdata = bus.bus_wdata;
            end
            if (bus.bus_re && !prev_re) begin
                re_rises++;
                seen_addr = bus.bus_addr;
            end
            if (bus.bus_we) we_cycles++;
            if (bus.bus_re) re_cycles++;
            if (frame_err) err_pulses++;
            if (bus.bus_ack) begin
                bus.bus_ack = 1'b0;
                lat_cnt = 0;
            end else if (bus.bus_we || bus.bus_re) begin
                lat_cnt++;
                if (ack_lat > 0 && lat_cnt == ack_lat) begin
                    bus.bus_ack = 1'b1;
                    bus.bus_rdata = rd_val;
                end
            end else begin
                lat_cnt = 0;
            end
        end
        prev_we = bus.bus_we;
        prev_re = bus.bus_re;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk);
        ss_active = 1'b0;
        repeat (3) @(negedge clk);
        ss_active = 1'b1;
    endtask

    function automatic vec_t mk(input logic [31:0] b, input int n,
                                input int lat, input logic [7:0] rdata,
                                input int we, input int re,
                                input logic [6:0] addr,
                                input logic [7:0] wdata,
                                input int err, input logic [7:0] tx);
        vec_t v;
        v.by = b;
        v.n = n;
        v.lat = lat;
        v.rdata = rdata;
        v.exp_we = we;
        v.exp_re = re;
        v.exp_addr = addr;
        v.exp_wdata = wdata;
        v.exp_err = err;
        v.exp_tx = tx;
        return v;
    endfunction

    // Frame-level reference: what one frame should do on the bus and MISO.
    function automatic vec_t model(input int kind, input logic [6:0] addr,
                                   input logic [7:0] data, input int lat,
                                   input logic [7:0] rdata,
                                   input logic [31:0] junk, input int extra);
        vec_t v;
        int tmo;
        tmo = (lat == 0) ? 1 : 0;
        v = mk(32'h0, 0, lat, rdata, 0, 0, addr, data, 0, 8'h00);
        if (kind == 0) begin
            v.by = {SYNC_BYTE_DEF, 1'b1, addr, data, 8'h00};
            v.n = 4;
            v.exp_we = 1;
            v.exp_err = tmo;
        end else if (kind == 1) begin
            v.by = {SYNC_BYTE_DEF, 1'b0, addr, 8'h00, 8'h00};
            v.n = 3;
            v.exp_re = 1;
            v.exp_err = tmo;
            v.exp_tx = (tmo == 1) ? ERR_BYTE_DEF : rdata;
        end else begin
            v.by = junk;
            if (v.by[3] == SYNC_BYTE_DEF) v.by[3] = 8'h55;
            v.n = 1 + extra;
            v.exp_err = 1;
        end
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int we0, re0, err0;
        ack_lat = v.lat;
        rd_val = v.rdata;
        settle();
        we0 = we_rises;
        re0 = re_rises;
        err0 = err_pulses;
        for (int i = 0; i < v.n; i++) begin
            if (i == v.n - 1) chk({tag, ".tx"}, 32'(tx_byte), 32'(v.exp_tx));
            send(v.by[3-i], GAP);
        end
        #1;
        chk({tag, ".tx_end"}, 32'(tx_byte), 32'h0);
        end_frame();
        settle();
        chk({tag, ".we"}, we_rises - we0, v.exp_we);
        chk({tag, ".re"}, re_rises - re0, v.exp_re);
        chk({tag, ".err"}, err_pulses - err0, v.exp_err);
        if (v.exp_we != 0 || v.exp_re != 0)
            chk({tag, ".addr"}, 32'(seen_addr), 32'(v.exp_addr));
        if (v.exp_we != 0)
            chk({tag, ".wdata"}, 32'(seen_wdata), 32'(v.exp_wdata));
        chk({tag, ".state"}, 32'(dut.state_q), 32'(ST_IDLE));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl [8];
        vec_t v;
        int kind, c0, c1, e0, w0, r0;
        logic [6:0] ra;

        tbl[0] = mk(32'h89A42300, 4, 2, 8'h00, 1, 0, 7'h24, 8'h23, 0, 8'h00);
        tbl[1] = mk(32'h89240000, 3, 3, 8'h23, 0, 1, 7'h24, 8'h00, 0, 8'h23);
        tbl[2] = mk(32'h55898101, 4, 1, 8'h00, 0, 0, 7'h00, 8'h00, 1, 8'h00);
        tbl[3] = mk(32'h89810100, 4, 1, 8'h00, 1, 0, 7'h01, 8'h01, 0, 8'h00);
        tbl[4] = mk(32'h89240000, 3, 0, 8'h00, 0, 1, 7'h24, 8'h00, 1, 8'hEE);
        tbl[5] = mk(32'h89805A00, 4, 1, 8'h00, 1, 0, 7'h00, 8'h5A, 0, 8'h00);
        tbl[6] = mk(32'h897E0000, 3, 1, 8'hFF, 0, 1, 7'h7E, 8'h00, 0, 8'hFF);
        tbl[7] = mk(32'h8990AA00, 4, 0, 8'h00, 1, 0, 7'h10, 8'hAA, 1, 8'h00);

        rst = 1'b1;
        ss_active = 1'b0;
        rx_valid = 1'b0;
        rx_byte = 8'h00;
        ack_lat = 1;
        rd_val = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.tx", 32'(tx_byte), 32'h0);
        chk("rst.err", 32'(frame_err), 32'h0);
        chk("rst.we", 32'(bus.bus_we), 32'h0);
        chk("rst.re", 32'(bus.bus_re), 32'h0);
        chk("rst.addr", 32'(bus.bus_addr), 32'h0);
        chk("rst.wdata", 32'(bus.bus_wdata), 32'h0);
        chk("rst.state", 32'(dut.state_q), 32'(ST_IDLE));
        rst = 1'b0;
        ss_active = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        for (int k = 0; k < NRAND; k++) begin
            kind = int'($urandom_range(0, 2));
            ra = 7'($urandom_range(0, 126));
            v = model(kind, ra, 8'($urandom), int'($urandom_range(0, 5)),
                      8'($urandom), $urandom, int'($urandom_range(0, 2)));
            run_vec(v, $sformatf("rnd%0d", k));
        end

        // Request timing: rises one cycle after the byte, lasts BUS_TIMEOUT.
        ack_lat = 0;
        settle();
        c0 = re_cycles;
        e0 = err_pulses;
        send(SYNC_BYTE_DEF, GAP);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte = 8'h24;
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        chk("tmo.rise", 32'(bus.bus_re), 32'h1);
        repeat (GAP) @(negedge clk);
        #1;
        chk("tmo.len", re_cycles - c0, 16);
        chk("tmo.err", err_pulses - e0, 1);
        chk("tmo.tx", 32'(tx_byte), 32'hEE);
        send(8'h00, 4);
        end_frame();

        c1 = we_cycles;
        run_vec(mk(32'h89C45500, 4, 3, 8'h00, 1, 0, 7'h44, 8'h55, 0, 8'h00),
                "ack3");
        chk("ack3.len", we_cycles - c1, 3);

        // Deselect after the command byte of a write.
        ack_lat = 1;
        settle();
        w0 = we_rises;
        e0 = err_pulses;
        send(SYNC_BYTE_DEF, GAP);
        send(8'hA4, GAP);
        end_frame();
        settle();
        chk("cut.we", we_rises - w0, 0);
        chk("cut.err", err_pulses - e0, 0);
        chk("cut.state", 32'(dut.state_q), 32'(ST_IDLE));
        run_vec(tbl[0], "cut.next");

        // Byte arriving in the same cycle as deselect is dropped.
        settle();
        w0 = we_rises;
        r0 = re_rises;
        e0 = err_pulses;
        send(SYNC_BYTE_DEF, GAP);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte = 8'h24;
        ss_active = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        chk("sim.state", 32'(dut.state_q), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        ss_active = 1'b1;
        settle();
        chk("sim.err", err_pulses - e0, 0);
        chk("sim.acc", (we_rises - w0) + (re_rises - r0), 0);

        // Overrun while a read is outstanding; the read still times out.
        ack_lat = 0;
        settle();
        r0 = re_rises;
        c0 = re_cycles;
        e0 = err_pulses;
        send(SYNC_BYTE_DEF, GAP);
        send(8'h24, 2);
        send(8'h00, 1);
        #1;
        chk("ovr.state", 32'(dut.state_q), 32'(ST_HUNT));
        repeat (GAP) @(negedge clk);
        #1;
        chk("ovr.err", err_pulses - e0, 2);
        chk("ovr.re", re_rises - r0, 1);
        chk("ovr.len", re_cycles - c0, 16);
        chk("ovr.tx", 32'(tx_byte), 32'hEE);
        end_frame();
        settle();
        chk("ovr.idle", 32'(dut.state_q), 32'(ST_IDLE));

        // Reset during an outstanding write.
        send(SYNC_BYTE_DEF, GAP);
        send(8'hA4, GAP);
        send(8'h23, 3);
        #1;
        chk("rma.we_on", 32'(bus.bus_we), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rma.we_off", 32'(bus.bus_we), 32'h0);
        chk("rma.state", 32'(dut.state_q), 32'(ST_IDLE));
        rst = 1'b0;
        end_frame();

`ifdef SPI_REG_BRIDGE_ERRCNT_EN
        ack_lat = 1;
        for (int i = 0; i < 3; i++) begin
            send(8'h55, 4);
            end_frame();
        end
        run_vec(mk(32'h897F0000, 3, 1, 8'h00, 0, 0, 7'h7F, 8'h00, 0, 8'h03),
                "cnt.rd3");
        run_vec(mk(32'h89FF1200, 4, 1, 8'h00, 0, 0, 7'h7F, 8'h12, 0, 8'h00),
                "cnt.clr");
        run_vec(mk(32'h897F0000, 3, 1, 8'h00, 0, 0, 7'h7F, 8'h00, 0, 8'h00),
                "cnt.rd0");
`else
        run_vec(mk(32'h897F0000, 3, 1, 8'h3C, 0, 1, 7'h7F, 8'h00, 0, 8'h3C),
                "fwd7f");
`endif

        chk("overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
